bomb_timer_display: RTL and testbench



---
 rtl/bomb_pkg.sv | 39 +++
 rtl/bomb_timer_display_debounce.sv | 43 ++++
 rtl/bomb_timer_display.sv | 207 ++++++++++++++++++++
 tb/tb_bomb_timer_display.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bomb_pkg.sv
// bomb_pkg: shared encodings, glyphs and helpers for the
// bomb-defusal timing and display core.
package bomb_pkg;

  typedef enum logic [1:0] {
    GS_IDLE   = 2'd0,
    GS_PREARM = 2'd1,
    GS_DEFUSE = 2'd2,
    GS_END    = 2'd3
  } game_state_e;

  typedef enum logic [1:0] {
    CD_IDLE     = 2'd0,
    CD_PRE_RUN  = 2'd1,
    CD_PRE_DONE = 2'd2,
    CD_DEF_RUN  = 2'd3
  } cd_state_e;

  localparam int MAX_SECONDS = 30;

  // Row 0 in the top byte, bit 7 of each byte is the leftmost column.
  localparam logic [63:0] BOMB_GLYPH  = 64'h04_18_3C_7E_7E_7E_3C_18;
  localparam logic [63:0] SMILE_GLYPH = 64'h3C_42_A5_81_A5_99_42_3C;
  localparam logic [63:0] BOOM_GLYPH  = 64'h99_5A_3C_FF_FF_3C_5A_99;

  function automatic logic [7:0] glyph_row(
    input logic [63:0] g,
    input logic [2:0]  r
  );
    logic [63:0] s;
    s = g << (8 * r);
    return s[63:56];
  endfunction

  function automatic logic [4:0] clamp_secs(input logic [4:0] s);
    return (s > 5'(MAX_SECONDS)) ? 5'(MAX_SECONDS) : s;
  endfunction

endpackage

// File: rtl/bomb_timer_display_debounce.sv
// debounce_filter: 2-flop synchronizer plus a stability counter
// that accepts a new level only after it has held long enough.
module debounce_filter
  import bomb_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Synchronize, then count consecutive cycles of disagreement.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 != level) begin
        if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
          level <= s2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/bomb_timer_display.sv
// bomb_timer_display: debouncer, two-phase seconds countdown and
// LED-matrix animator (animator built only with BOMB_CARTOON_EN).
module bomb_timer_display
  import bomb_pkg::*;
#(
  parameter int CLK_HZ       = 1000000,
  parameter int DEBOUNCE_CYC = 20000,
  parameter int SCAN_CYC     = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       btn_level,
  input  logic [1:0] game_state,
  input  logic [4:0] countdown_times,
  input  logic       success,
  output logic [4:0] leave_times,
  output logic [1:0] countdown_state,
  output logic [7:0] row,
  output logic [7:0] red,
  output logic [7:0] green
);

  localparam int TW = $clog2(CLK_HZ + 1);

  game_state_e   gs;
  cd_state_e     cs;
  cd_state_e     ns;
  logic [4:0]    lt;
  logic [4:0]    lt_n;
  logic [4:0]    load_val;
  logic [TW-1:0] tick_cnt;
  logic          tick_done;
  logic          tick_clr;

  assign gs              = game_state_e'(game_state);
  assign load_val        = clamp_secs(countdown_times);
  assign tick_done       = (tick_cnt == TW'(CLK_HZ - 1));
  assign leave_times     = lt;
  assign countdown_state = cs;

  debounce_filter #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_deb (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_raw),
    .level(btn_level)
  );

  // One-second tick counter, restarted on every load.
  always_ff @(posedge clk) begin
    if (rst || tick_clr || tick_done) tick_cnt <= '0;
    else                              tick_cnt <= tick_cnt + 1'b1;
  end

  // Countdown state and seconds register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs <= CD_IDLE;
      lt <= '0;
    end else begin
      cs <= ns;
      lt <= lt_n;
    end
  end

  // Countdown next state: idle/end override, then per-phase behaviour.
  always_comb begin
    ns       = cs;
    lt_n     = lt;
    tick_clr = 1'b0;
    if (gs == GS_IDLE) begin
      ns       = CD_IDLE;
      lt_n     = '0;
      tick_clr = 1'b1;
    end else if (gs == GS_END) begin
      ns = CD_IDLE;
    end else begin
      unique case (cs)
        CD_IDLE: begin
          if (gs == GS_PREARM) begin
            lt_n     = load_val;
            tick_clr = 1'b1;
            ns       = CD_PRE_RUN;
          end
        end
        CD_PRE_RUN: begin
          if (lt == '0) begin
            ns = CD_PRE_DONE;
          end else if (tick_done) begin
            lt_n = lt - 5'd1;
            if (lt == 5'd1) ns = CD_PRE_DONE;
          end
        end
        CD_PRE_DONE: begin
          if (gs == GS_DEFUSE) begin
            tick_clr = 1'b1;
            if (load_val == '0) begin
              lt_n = '0;
              ns   = CD_IDLE;
            end else begin
              lt_n = load_val;
              ns   = CD_DEF_RUN;
            end
          end
        end
        CD_DEF_RUN: begin
          if (lt == '0) begin
            ns = CD_IDLE;
          end else if (tick_done) begin
            lt_n = lt - 5'd1;
            if (lt == 5'd1) ns = CD_IDLE;
          end
        end
      endcase
    end
  end

`ifdef BOMB_CARTOON_EN
  localparam int HALF = CLK_HZ / 2;
  localparam int SW   = $clog2(SCAN_CYC + 1);
  localparam int BW   = $clog2(HALF + 1);

  logic [2:0]    r;
  logic [SW-1:0] scan_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;
  logic [3:0]    fuse_n;
  logic [7:0]    fuse;
  logic [7:0]    body;
  logic [7:0]    red_n;
  logic [7:0]    green_n;

  // Row scan index advances every SCAN_CYC cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r        <= '0;
      scan_cnt <= '0;
    end else if (scan_cnt == SW'(SCAN_CYC - 1)) begin
      r        <= r + 3'd1;
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Half-second blink phase, restarting "on" whenever the end state is entered.
  always_ff @(posedge clk) begin
    if (rst || gs != GS_END) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BW'(HALF - 1)) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Column bytes for the current row.
  always_comb begin
    red_n   = '0;
    green_n = '0;
    fuse_n  = (lt > 5'd8) ? 4'd8 : lt[3:0];
    fuse    = ~(8'hFF >> fuse_n);
    body    = glyph_row(BOMB_GLYPH, r);
    unique case (gs)
      GS_IDLE: begin
      end
      GS_PREARM: begin
        green_n = body;
      end
      GS_DEFUSE: begin
        if (lt > 5'd5) green_n = body;
        else           red_n   = body;
        if (r == 3'd0) red_n = red_n | fuse;
      end
      GS_END: begin
        if (success)       green_n = glyph_row(SMILE_GLYPH, r);
        else if (blink_on) red_n   = glyph_row(BOOM_GLYPH, r);
      end
    endcase
  end

  // Registered matrix drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      row   <= 8'hFE;
      red   <= '0;
      green <= '0;
    end else begin
      row   <= ~(8'b1 << r);
      red   <= red_n;
      green <= green_n;
    end
  end
`else
  logic unused_anim;

  assign unused_anim = success ^ (SCAN_CYC == 0);
  assign row         = 8'hFF;
  assign red         = 8'h00;
  assign green       = 8'h00;
`endif

endmodule

// File: tb/tb_bomb_timer_display.sv
// tb_bomb_timer_display: directed checks of debounce, countdown
// phases and matrix output with scaled-down timing parameters.
module tb_bomb_timer_display;
  import bomb_pkg::*;

  localparam int C = 40;
  localparam int D = 20;
  localparam int S = 4;
  localparam int H = C / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_raw;
  logic       btn_level;
  logic [1:0] game_state;
  logic [4:0] countdown_times;
  logic       success;
  logic [4:0] leave_times;
  logic [1:0] countdown_state;
  logic [7:0] row;
  logic [7:0] red;
  logic [7:0] green;

  int checks = 0;
  int failures = 0;
  int ncyc = 0;
  logic rose;

  bomb_timer_display #(
    .CLK_HZ(C),
    .DEBOUNCE_CYC(D),
    .SCAN_CYC(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .game_state(game_state),
    .countdown_times(countdown_times),
    .success(success),
    .leave_times(leave_times),
    .countdown_state(countdown_state),
    .row(row),
    .red(red),
    .green(green)
  );

  always #5 clk = ~clk;

  // Cycles since reset, used to model the scan index.
  always @(posedge clk) begin
    if (rst) ncyc <= 0;
    else     ncyc <= ncyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int ridx();
    return ((ncyc - 1) / S) % 8;
  endfunction

  function automatic logic [7:0] grow(input logic [63:0] g, input int i);
    logic [63:0] t;
    t = g;
    return t[63 - 8 * i -: 8];
  endfunction

  function automatic logic [7:0] fuse_of(input int n);
    logic [7:0] m;
    m = 8'h00;
    for (int b = 0; b < 8; b++) if (b < n) m[7 - b] = 1'b1;
    return m;
  endfunction

  function automatic logic [7:0] anim(input logic [7:0] v);
`ifdef BOMB_CARTOON_EN
    return v;
`else
    return 8'h00 & v;
`endif
  endfunction

  function automatic logic [7:0] exp_row();
`ifdef BOMB_CARTOON_EN
    logic [7:0] one;
    one = 8'b1 << ridx();
    return ~one;
`else
    return 8'hFF;
`endif
  endfunction

  function automatic logic [7:0] rst_row();
`ifdef BOMB_CARTOON_EN
    return 8'hFE;
`else
    return 8'hFF;
`endif
  endfunction

  initial begin
    int i;
    rst = 1'b1;
    btn_raw = 1'b0;
    game_state = 2'd0;
    countdown_times = 5'd0;
    success = 1'b0;
    tick(2);
    check("rst_btn", btn_level, 0);
    check("rst_lt", leave_times, 0);
    check("rst_cs", countdown_state, 0);
    check("rst_row", row, rst_row());
    check("rst_red", red, 0);
    check("rst_green", green, 0);
    rst = 1'b0;
    tick(1);

    rose = 1'b0;
    for (int k = 0; k < 20; k++) begin
      btn_raw = ~btn_raw;
      for (int j = 0; j < 5; j++) begin
        tick(1);
        rose = rose | btn_level;
      end
    end
    check("deb_bounce", rose, 0);
    btn_raw = 1'b1;
    tick(D + 1);
    check("deb_early", btn_level, 0);
    tick(1);
    check("deb_rise", btn_level, 1);
    btn_raw = 1'b0;
    tick(D + 1);
    check("deb_hold", btn_level, 1);
    tick(1);
    check("deb_fall", btn_level, 0);

    countdown_times = 5'd5;
    game_state = 2'd1;
    tick(1);
    check("pre_load_lt", leave_times, 5);
    check("pre_load_cs", countdown_state, 1);
    check("pre_green", green, anim(grow(BOMB_GLYPH, ridx())));
    check("pre_red", red, 0);
    for (i = 4; i >= 0; i--) begin
      tick(C - 1);
      check("pre_before", leave_times, i + 1);
      tick(1);
      check("pre_dec", leave_times, i);
      if (i > 0) check("pre_cs_run", countdown_state, 1);
    end
    check("pre_done_cs", countdown_state, 2);

    countdown_times = 5'd3;
    game_state = 2'd2;
    tick(1);
    check("def_load_cs", countdown_state, 3);
    check("def_load_lt", leave_times, 3);
    tick(1);
    i = ridx();
    check("def_red", red,
          anim(grow(BOMB_GLYPH, i) | ((i == 0) ? fuse_of(3) : 8'h00)));
    check("def_green", green, 0);
    tick(3 * C - 2);
    check("def_last_cs", countdown_state, 3);
    check("def_last_lt", leave_times, 1);
    tick(1);
    check("def_exp_cs", countdown_state, 0);
    check("def_exp_lt", leave_times, 0);

    game_state = 2'd0;
    tick(1);
    countdown_times = 5'd1;
    game_state = 2'd1;
    tick(1);
    tick(C);
    check("pre2_cs", countdown_state, 2);
    countdown_times = 5'd9;
    game_state = 2'd2;
    tick(1);
    check("suc_load_lt", leave_times, 9);
    tick(1);
    i = ridx();
    check("suc_green9", green, anim(grow(BOMB_GLYPH, i)));
    check("suc_red9", red, anim((i == 0) ? fuse_of(8) : 8'h00));
    tick(2 * C - 1);
    check("suc_lt7", leave_times, 7);
    tick(5);
    success = 1'b1;
    game_state = 2'd3;
    tick(1);
    check("suc_cs", countdown_state, 0);
    check("suc_lt", leave_times, 7);
    for (int k = 0; k < 8; k++) begin
      check("suc_smile", green, anim(grow(SMILE_GLYPH, ridx())));
      check("suc_red0", red, 0);
      tick(S);
    end
    check("suc_lt_hold", leave_times, 7);

    game_state = 2'd0;
    tick(1);
    success = 1'b0;
    game_state = 2'd3;
    tick(1);
    check("boom_on", red, anim(grow(BOOM_GLYPH, ridx())));
    check("boom_green", green, 0);
    tick(H - 1);
    check("boom_on_end", red, anim(grow(BOOM_GLYPH, ridx())));
    tick(1);
    check("boom_off", red, 0);
    tick(H - 1);
    check("boom_off_end", red, 0);
    tick(1);
    check("boom_on2", red, anim(grow(BOOM_GLYPH, ridx())));
    for (int k = 0; k < 8; k++) begin
      tick(S);
      check("scan_row", row, exp_row());
    end

    game_state = 2'd0;
    btn_raw = 1'b1;
    tick(1);
    countdown_times = 5'd1;
    game_state = 2'd1;
    tick(1);
    tick(C);
    countdown_times = 5'd15;
    game_state = 2'd2;
    tick(1);
    check("mid_load", leave_times, 15);
    tick(3 * C);
    check("mid_lt12", leave_times, 12);
    check("mid_btn", btn_level, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_lt", leave_times, 0);
    check("mid_rst_cs", countdown_state, 0);
    check("mid_rst_btn", btn_level, 0);
    check("mid_rst_row", row, rst_row());
    check("mid_rst_red", red, 0);
    check("mid_rst_green", green, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
